// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-requester memory read-port arbiter:
// FSM states and grant/owner identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arbState_t;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to the requester that was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic reqA,
  input  logic reqB,
  input  logic lastGrant,
  output logic gntA,
  output logic gntB
);

  assign gntA = reqA && (!reqB || (lastGrant == GNT_B));
  assign gntB = reqB && (!reqA || (lastGrant == GNT_A));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory read port between requesters A and B, one read in flight.
// Optional WAIT timeout with error response is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter bit PRIO_A_FIRST = 1'b1,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValidA,
  input  logic [ADDR_W-1:0] reqAddrA,
  output logic              reqReadyA,
  output logic              respValidA,
  output logic [DATA_W-1:0] respDataA,
  output logic              respErrA,
  input  logic              reqValidB,
  input  logic [ADDR_W-1:0] reqAddrB,
  output logic              reqReadyB,
  output logic              respValidB,
  output logic [DATA_W-1:0] respDataB,
  output logic              respErrB,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memReady,
  input  logic              memReadValid,
  input  logic [ADDR_W-1:0] memAddrOut,
  input  logic [DATA_W-1:0] memDout
);

  // Handshake: a request transfers in the cycle reqValid && reqReady are both high;
  // reqReady is combinational and only asserted in IDLE with memReady high.
  // Responses are single-cycle respValid pulses with no back-pressure.

  localparam logic RESET_GRANT = PRIO_A_FIRST ? GNT_B : GNT_A;

  arbState_t         state, stateNext;
  logic              lastGrant, owner;
  logic [ADDR_W-1:0] addrReg, winAddr;
  logic [DATA_W-1:0] dataA, dataB;
  logic              errReg;
  logic              gntA, gntB;
  logic              grant, match, timeoutHit, finish;

  rr_arbiter2 uArb (
    .reqA      (reqValidA),
    .reqB      (reqValidB),
    .lastGrant (lastGrant),
    .gntA      (gntA),
    .gntB      (gntB)
  );

  assign grant   = !rst && (state == ST_IDLE) && memReady && (gntA || gntB);
  assign winAddr = gntB ? reqAddrB : reqAddrA;
  assign match   = memReadValid && (memAddrOut == addrReg);
  assign finish  = (state == ST_WAIT) && (match || timeoutHit);

  always_comb begin
    stateNext = state;
    reqReadyA = 1'b0;
    reqReadyB = 1'b0;
    memReq    = 1'b0;
    memAddr   = addrReg;
    unique case (state)
      ST_IDLE: begin
        memAddr = '0;
        if (grant) begin
          reqReadyA = gntA;
          reqReadyB = gntB;
          memReq    = 1'b1;
          memAddr   = winAddr;
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: if (match || timeoutHit) stateNext = ST_RESP;
      ST_RESP: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lastGrant <= RESET_GRANT;
      owner     <= GNT_A;
      addrReg   <= '0;
      dataA     <= '0;
      dataB     <= '0;
      errReg    <= 1'b0;
    end else begin
      state <= stateNext;
      if (grant) begin
        addrReg <= winAddr;
        owner   <= gntB ? GNT_B : GNT_A;
      end
      // A matching beat in the limit cycle wins over the timeout.
      if (finish) begin
        errReg <= !match;
        if (owner == GNT_A) dataA <= match ? memDout : '0;
        else                dataB <= match ? memDout : '0;
      end
      if (state == ST_RESP) lastGrant <= owner;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] waitCnt;

  assign timeoutHit = (state == ST_WAIT) && !match && (waitCnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           waitCnt <= '0;
    else if (state == ST_WAIT && stateNext == ST_WAIT) waitCnt <= waitCnt + CNT_W'(1);
    else                                               waitCnt <= '0;
  end
`else
  assign timeoutHit = 1'b0;
`endif

  assign respValidA = (state == ST_RESP) && (owner == GNT_A);
  assign respValidB = (state == ST_RESP) && (owner == GNT_B);
  assign respErrA   = respValidA && errReg;
  assign respErrB   = respValidB && errReg;
  assign respDataA  = dataA;
  assign respDataB  = dataB;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written
// sequences for back-to-back ties and the WAIT timeout (ARB_TIMEOUT_EN aware).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValidA = 1'b0, reqValidB = 1'b0;
  logic [31:0] reqAddrA = '0, reqAddrB = '0;
  logic        reqReadyA, reqReadyB, respValidA, respValidB, respErrA, respErrB;
  logic [31:0] respDataA, respDataB, memAddr;
  logic        memReq;
  logic        memReady = 1'b0, memReadValid = 1'b0;
  logic [31:0] memAddrOut = '0, memDout = '0;

  int nVec = 0;
  int nErr = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic rst, vA; logic [31:0] aA; logic vB; logic [31:0] aB;
    logic mRdy, mRv; logic [31:0] mAo, mDo;
    logic rdyA, rdyB, mReq; logic [31:0] mAddr;
    logic rvA; logic [31:0] rdA; logic rvB; logic [31:0] rdB;
  } vec_t;

  vec_t tbl[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_A_FIRST(1'b1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .reqValidA(reqValidA), .reqAddrA(reqAddrA), .reqReadyA(reqReadyA),
    .respValidA(respValidA), .respDataA(respDataA), .respErrA(respErrA),
    .reqValidB(reqValidB), .reqAddrB(reqAddrB), .reqReadyB(reqReadyB),
    .respValidB(respValidB), .respDataB(respDataB), .respErrB(respErrB),
    .memReq(memReq), .memAddr(memAddr), .memReady(memReady),
    .memReadValid(memReadValid), .memAddrOut(memAddrOut), .memDout(memDout)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic r, logic vA, logic [31:0] aA, logic vB, logic [31:0] aB,
    logic mRdy, logic mRv, logic [31:0] mAo, logic [31:0] mDo,
    logic rdyA, logic rdyB, logic mReq, logic [31:0] mAddr,
    logic rvA, logic [31:0] rdA, logic rvB, logic [31:0] rdB);
    vec_t v;
    v.rst = r; v.vA = vA; v.aA = aA; v.vB = vB; v.aB = aB;
    v.mRdy = mRdy; v.mRv = mRv; v.mAo = mAo; v.mDo = mDo;
    v.rdyA = rdyA; v.rdyB = rdyB; v.mReq = mReq; v.mAddr = mAddr;
    v.rvA = rvA; v.rdA = rdA; v.rvB = rvB; v.rdB = rdB;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input vec_t v);
    rst = v.rst; reqValidA = v.vA; reqAddrA = v.aA; reqValidB = v.vB; reqAddrB = v.aB;
    memReady = v.mRdy; memReadValid = v.mRv; memAddrOut = v.mAo; memDout = v.mDo;
  endtask

  task automatic idleInputs();
    reqValidA = 1'b0; reqValidB = 1'b0; reqAddrA = '0; reqAddrB = '0;
    memReady = 1'b0; memReadValid = 1'b0; memAddrOut = '0; memDout = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    idleInputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard compare for one table row
  task automatic checkVec(input int idx, input vec_t v);
    logic [102:0] act, exp;
    act = {reqReadyA, reqReadyB, memReq, memAddr, respValidA, respDataA, respErrA,
           respValidB, respDataB, respErrB};
    exp = {v.rdyA, v.rdyB, v.mReq, v.mAddr, v.rvA, v.rdA, 1'b0, v.rvB, v.rdB, 1'b0};
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL vec%0d: got {rdyA,rdyB,memReq,memAddr,rvA,rdA,erA,rvB,rdB,erB}=%h want %h",
               idx, act, exp);
    end
  endtask

  initial begin
    logic        expOwner, respSeen, errSeen, addrBad;
    logic [31:0] expAddr, expData, dataSeen;
    int          respAt;

    // reset state and test 1: A alone, zero-wait memory
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,32'h4,0,0, 1,0,0,0,               1,0,1,32'h4, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,32'h4,32'h83210000,    0,0,0,32'h4, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,                   0,0,0,32'h4, 1,32'h83210000,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,32'h83210000,0,0));
    // test 2: tie after reset goes to A, then B
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,32'h0,1,32'h8, 1,0,0,0,           1,0,1,32'h0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h8, 1,1,32'h0,32'hB7000080, 0,0,0,32'h0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h8, 1,0,0,0,               0,0,0,32'h0, 1,32'hB7000080,0,0));
    tbl.push_back(mk(0,0,0,1,32'h8, 1,0,0,0,               0,1,1,32'h8, 0,32'hB7000080,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,32'h8,32'h23a03000,    0,0,0,32'h8, 0,32'hB7000080,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,                   0,0,0,32'h8, 0,32'hB7000080,1,32'h23a03000));
    // test 4: stale beat ignored, matching beat 3 cycles later; B waits meanwhile
    tbl.push_back(mk(0,1,32'h4,0,0, 1,0,0,0,               1,0,1,32'h4, 0,32'hB7000080,0,32'h23a03000));
    tbl.push_back(mk(0,0,0,1,32'h10, 1,1,32'hC,32'hDEAD0000, 0,0,0,32'h4, 0,32'hB7000080,0,32'h23a03000));
    tbl.push_back(mk(0,0,0,1,32'h10, 1,0,0,0,              0,0,0,32'h4, 0,32'hB7000080,0,32'h23a03000));
    tbl.push_back(mk(0,0,0,1,32'h10, 1,0,0,0,              0,0,0,32'h4, 0,32'hB7000080,0,32'h23a03000));
    tbl.push_back(mk(0,0,0,1,32'h10, 1,1,32'h4,32'h12345678, 0,0,0,32'h4, 0,32'hB7000080,0,32'h23a03000));
    tbl.push_back(mk(0,0,0,1,32'h10, 1,0,0,0,              0,0,0,32'h4, 1,32'h12345678,0,32'h23a03000));
    tbl.push_back(mk(0,0,0,1,32'h10, 1,0,0,0,              0,1,1,32'h10, 0,32'h12345678,0,32'h23a03000));
    tbl.push_back(mk(0,0,0,0,0, 0,1,32'h10,32'h55AA55AA,   0,0,0,32'h10, 0,32'h12345678,0,32'h23a03000));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,                   0,0,0,32'h10, 0,32'h12345678,1,32'h55AA55AA));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,32'h12345678,0,32'h55AA55AA));
    // test 3: memReady low for 5 cycles, grant on the first ready cycle
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,1,32'h20,0,0, 0,0,0,0,            0,0,0,0, 0,32'h12345678,0,32'h55AA55AA));
    tbl.push_back(mk(0,1,32'h20,0,0, 1,0,0,0,              1,0,1,32'h20, 0,32'h12345678,0,32'h55AA55AA));
    tbl.push_back(mk(0,0,0,0,0, 0,1,32'h20,32'h0BADF00D,   0,0,0,32'h20, 0,32'h12345678,0,32'h55AA55AA));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,                   0,0,0,32'h20, 1,32'h0BADF00D,0,32'h55AA55AA));
    // request withdrawn before memReady: no grant
    tbl.push_back(mk(0,1,32'h24,0,0, 0,0,0,0,              0,0,0,0, 0,32'h0BADF00D,0,32'h55AA55AA));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,                   0,0,0,0, 0,32'h0BADF00D,0,32'h55AA55AA));
    // test 6: reset in WAIT, late beat ignored, next tie to A
    tbl.push_back(mk(0,1,32'h4,0,0, 1,0,0,0,               1,0,1,32'h4, 0,32'h0BADF00D,0,32'h55AA55AA));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,32'h4,32'h0000FFFF,    0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,32'h30,1,32'h34, 1,0,0,0,         1,0,1,32'h30, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h34, 1,1,32'h30,32'h600D0001, 0,0,0,32'h30, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h34, 1,0,0,0,              0,0,0,32'h30, 1,32'h600D0001,0,0));
    tbl.push_back(mk(0,0,0,1,32'h34, 1,0,0,0,              0,1,1,32'h34, 0,32'h600D0001,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,32'h34,32'h600D0002,   0,0,0,32'h34, 0,32'h600D0001,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,                   0,0,0,32'h34, 0,32'h600D0001,1,32'h600D0002));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      checkVec(i, tbl[i]);
    end

    // 8 back-to-back ties after reset alternate A,B,A,B,...
    doReset();
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 1'b0 : 1'b1);
    for (int i = 0; i < 8; i++) begin
      expOwner = exp_q.pop_front();
      expAddr  = expOwner ? 32'h200 : 32'h100;
      expData  = 32'hA0000000 + 32'(i);
      @(negedge clk);
      reqValidA = 1'b1; reqAddrA = 32'h100; reqValidB = 1'b1; reqAddrB = 32'h200;
      memReady = 1'b1; memReadValid = 1'b0;
      #1;
      nVec++;
      if (!((reqReadyA ^ reqReadyB) && reqReadyB == expOwner && memReq && memAddr == expAddr)) begin
        nErr++;
        $display("FAIL tie%0d grant: got rdyA=%b rdyB=%b memReq=%b memAddr=%h want owner=%b addr=%h",
                 i, reqReadyA, reqReadyB, memReq, memAddr, expOwner, expAddr);
      end
      @(negedge clk);
      memReadValid = 1'b1; memAddrOut = expAddr; memDout = expData;
      @(negedge clk);
      memReadValid = 1'b0;
      #1;
      nVec++;
      if (!(respValidA == !expOwner && respValidB == expOwner && !reqReadyA && !reqReadyB &&
            (expOwner ? respDataB : respDataA) == expData)) begin
        nErr++;
        $display("FAIL tie%0d resp: got rvA=%b rvB=%b rdA=%h rdB=%h want owner=%b data=%h",
                 i, respValidA, respValidB, respDataA, respDataB, expOwner, expData);
      end
    end

    // WAIT with no memory response: timeout error or indefinite wait
    doReset();
    @(negedge clk);
    reqValidB = 1'b1; reqAddrB = 32'h40; memReady = 1'b1;
    #1;
    nVec++;
    if (!(reqReadyB && memReq && memAddr == 32'h40)) begin
      nErr++;
      $display("FAIL to-grant: got rdyB=%b memReq=%b memAddr=%h want 1 1 00000040",
               reqReadyB, memReq, memAddr);
    end
    respAt = 0; respSeen = 1'b0; errSeen = 1'b0; addrBad = 1'b0; dataSeen = '1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      reqValidB = 1'b0;
      #1;
      if ((respValidA || respValidB) && !respSeen) begin
        respSeen = 1'b1; respAt = k; errSeen = respErrB; dataSeen = respDataB;
      end
      if (!respSeen && memAddr != 32'h40) addrBad = 1'b1;
    end
    nVec++;
`ifdef ARB_TIMEOUT_EN
    if (!(respAt == 17 && errSeen && dataSeen == 32'h0 && !addrBad)) begin
      nErr++;
      $display("FAIL timeout: got respAt=%0d err=%b data=%h addrBad=%b want 17 1 00000000 0",
               respAt, errSeen, dataSeen, addrBad);
    end
`else
    if (respSeen || addrBad) begin
      nErr++;
      $display("FAIL nowait-timeout: got respAt=%0d addrBad=%b want no response, addr held",
               respAt, addrBad);
    end
`endif
    doReset();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
